// File: rtl/ntt_bank_mem_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : ntt_bank_mem_ctrl_if
// Purpose  : Host load/unload, command and butterfly bus bundle for the NTT
//            dual-bank coefficient memory controller.
// Revision : 1.0 - initial release
// ============================================================================
interface ntt_bank_mem_ctrl_if #(
    parameter int DATA_WIDTH = 14,
    parameter int LOG_N      = 10
);
    logic                  cmd_valid;
    logic [1:0]            cmd;
    logic                  busy;
    logic                  done;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  bf_req;
    logic [LOG_N-1:0]      bf_addr0;
    logic [LOG_N-1:0]      bf_addr1;
    logic                  bf_last;
    logic [DATA_WIDTH-1:0] bf_q0;
    logic [DATA_WIDTH-1:0] bf_q1;
    logic                  bf_q_valid;
    logic [DATA_WIDTH-1:0] bf_d0;
    logic [DATA_WIDTH-1:0] bf_d1;
    logic                  conflict_err;

    modport slave (
        input  cmd_valid, cmd, in_valid, in_data, out_ready,
        input  bf_req, bf_addr0, bf_addr1, bf_last, bf_d0, bf_d1,
        output busy, done, in_ready, out_valid, out_data,
        output bf_q0, bf_q1, bf_q_valid, conflict_err
    );

    modport master (
        output cmd_valid, cmd, in_valid, in_data, out_ready,
        output bf_req, bf_addr0, bf_addr1, bf_last, bf_d0, bf_d1,
        input  busy, done, in_ready, out_valid, out_data,
        input  bf_q0, bf_q1, bf_q_valid, conflict_err
    );
endinterface
`default_nettype wire

// File: rtl/ntt_bank_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ntt_bank_mem_ctrl
// Purpose  : Dual-bank NTT coefficient memory with load/unload streaming,
//            butterfly read routing and pipelined write-back.
// Revision : 1.0 - initial release
// ============================================================================
module ntt_bank_mem_ctrl #(
    parameter int DATA_WIDTH = 14,
    parameter int LOG_N      = 10,
    parameter int WB_LATENCY = 7
) (
    input  wire logic          clk,
    input  wire logic          rst,
    ntt_bank_mem_ctrl_if.slave bus
);
    localparam int               c_RW   = LOG_N - 1;
    localparam int               c_ROWS = 1 << c_RW;
    localparam logic [LOG_N-1:0] c_LAST = '1;

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_LOAD    = 3'd1;
    localparam logic [2:0] c_ST_COMPUTE = 3'd2;
    localparam logic [2:0] c_ST_DRAIN   = 3'd3;
    localparam logic [2:0] c_ST_UNLOAD  = 3'd4;

    logic [2:0]            r_state;
    logic [LOG_N-1:0]      r_cnt;
    logic [LOG_N-1:0]      r_out_cnt;
    logic                  r_issue_done, r_done, r_conflict;

    logic [DATA_WIDTH-1:0] r_mem_b0 [c_ROWS];
    logic [DATA_WIDTH-1:0] r_mem_b1 [c_ROWS];
    logic [DATA_WIDTH-1:0] r_rdata_b0, r_rdata_b1;
    logic                  r_swap, r_bf_q_valid, r_rd_valid, r_ul_bank;

    logic [DATA_WIDTH-1:0] r_fifo [2];
    logic                  r_wr_ptr, r_rd_ptr;
    logic [1:0]            r_count;

    logic [WB_LATENCY-1:0] r_dl_vld, r_dl_bank0, r_dl_conf;
    logic [c_RW-1:0]       r_dl_row0 [WB_LATENCY];
    logic [c_RW-1:0]       r_dl_row1 [WB_LATENCY];

    logic                  w_bank0, w_bank1, w_push, w_conflict, w_beat_in;
    logic                  w_out_valid, w_pop, w_issue, w_cnt_bank, w_rd_en;
    logic [2:0]            w_occ;
    logic [c_RW-1:0]       w_row0, w_row1, w_cnt_row, w_rd_row_b0, w_rd_row_b1;
    logic                  w_wb_vld, w_wb_bank0, w_wb_conf;
    logic [c_RW-1:0]       w_wb_row0, w_wb_row1, w_wrow_b0, w_wrow_b1;
    logic                  w_we_b0, w_we_b1;
    logic [DATA_WIDTH-1:0] w_wdata_b0, w_wdata_b1, w_ul_rdata;

    // Parity bank map: neighbours in any single address bit never collide
    assign w_bank0     = ^bus.bf_addr0;
    assign w_bank1     = ^bus.bf_addr1;
    assign w_row0      = bus.bf_addr0[LOG_N-1:1];
    assign w_row1      = bus.bf_addr1[LOG_N-1:1];
    assign w_conflict  = (w_bank0 == w_bank1);
    assign w_push      = (r_state == c_ST_COMPUTE) && bus.bf_req;
    assign w_beat_in   = (r_state == c_ST_LOAD) && bus.in_valid;
    assign w_cnt_bank  = ^r_cnt;
    assign w_cnt_row   = r_cnt[LOG_N-1:1];

    // Issue an unload read only if the FIFO can hold it alongside what is in flight
    assign w_out_valid = (r_count != 2'd0);
    assign w_pop       = w_out_valid && bus.out_ready;
    assign w_occ       = {1'b0, r_count} + {2'b0, r_rd_valid} - {2'b0, w_pop};
    assign w_issue     = (r_state == c_ST_UNLOAD) && !r_issue_done && (w_occ < 3'd2);
    assign w_rd_en     = w_push || w_issue;
    assign w_ul_rdata  = r_ul_bank ? r_rdata_b1 : r_rdata_b0;

    assign w_wb_vld    = r_dl_vld[WB_LATENCY-1];
    assign w_wb_bank0  = r_dl_bank0[WB_LATENCY-1];
    assign w_wb_conf   = r_dl_conf[WB_LATENCY-1];
    assign w_wb_row0   = r_dl_row0[WB_LATENCY-1];
    assign w_wb_row1   = r_dl_row1[WB_LATENCY-1];

    always_comb begin
        w_rd_row_b0 = w_bank0 ? w_row1 : w_row0;
        w_rd_row_b1 = w_bank0 ? w_row0 : w_row1;
        if (r_state == c_ST_UNLOAD) begin
            w_rd_row_b0 = w_cnt_row;
            w_rd_row_b1 = w_cnt_row;
        end
    end

    // On a conflict only addr0's location is written back
    always_comb begin
        w_we_b0    = 1'b0;
        w_we_b1    = 1'b0;
        w_wrow_b0  = w_wb_row0;
        w_wrow_b1  = w_wb_row1;
        w_wdata_b0 = bus.bf_d0;
        w_wdata_b1 = bus.bf_d1;
        if (w_beat_in) begin
            w_we_b0    = !w_cnt_bank;
            w_we_b1    = w_cnt_bank;
            w_wrow_b0  = w_cnt_row;
            w_wrow_b1  = w_cnt_row;
            w_wdata_b0 = bus.in_data;
            w_wdata_b1 = bus.in_data;
        end else if (w_wb_vld) begin
            w_we_b0    = !(w_wb_conf && w_wb_bank0);
            w_we_b1    = !(w_wb_conf && !w_wb_bank0);
            w_wrow_b0  = w_wb_bank0 ? w_wb_row1 : w_wb_row0;
            w_wrow_b1  = w_wb_bank0 ? w_wb_row0 : w_wb_row1;
            w_wdata_b0 = w_wb_bank0 ? bus.bf_d1 : bus.bf_d0;
            w_wdata_b1 = w_wb_bank0 ? bus.bf_d0 : bus.bf_d1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_we_b0) r_mem_b0[w_wrow_b0] <= w_wdata_b0;
        if (w_we_b1) r_mem_b1[w_wrow_b1] <= w_wdata_b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdata_b0   <= '0;
            r_rdata_b1   <= '0;
            r_swap       <= 1'b0;
            r_bf_q_valid <= 1'b0;
            r_rd_valid   <= 1'b0;
            r_ul_bank    <= 1'b0;
            r_conflict   <= 1'b0;
            r_fifo[0]    <= '0;
            r_fifo[1]    <= '0;
            r_wr_ptr     <= 1'b0;
            r_rd_ptr     <= 1'b0;
            r_count      <= 2'd0;
            r_dl_vld     <= '0;
            r_dl_bank0   <= '0;
            r_dl_conf    <= '0;
            for (int i = 0; i < WB_LATENCY; i++) begin
                r_dl_row0[i] <= '0;
                r_dl_row1[i] <= '0;
            end
        end else begin
            if (w_rd_en) begin
                r_rdata_b0 <= r_mem_b0[w_rd_row_b0];
                r_rdata_b1 <= r_mem_b1[w_rd_row_b1];
            end
            if (w_push) begin
                r_swap <= w_bank0;
                if (w_conflict) r_conflict <= 1'b1;
            end
            if (w_issue) r_ul_bank <= w_cnt_bank;
            r_bf_q_valid <= w_push;
            r_rd_valid   <= w_issue;

            if (r_rd_valid) begin
                r_fifo[r_wr_ptr] <= w_ul_rdata;
                r_wr_ptr         <= ~r_wr_ptr;
            end
            if (w_pop) r_rd_ptr <= ~r_rd_ptr;
            r_count <= r_count + {1'b0, r_rd_valid} - {1'b0, w_pop};

            r_dl_vld   <= {r_dl_vld[WB_LATENCY-2:0], w_push};
            r_dl_bank0 <= {r_dl_bank0[WB_LATENCY-2:0], w_bank0};
            r_dl_conf  <= {r_dl_conf[WB_LATENCY-2:0], w_conflict};
            r_dl_row0[0] <= w_row0;
            r_dl_row1[0] <= w_row1;
            for (int i = 1; i < WB_LATENCY; i++) begin
                r_dl_row0[i] <= r_dl_row0[i-1];
                r_dl_row1[i] <= r_dl_row1[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= c_ST_IDLE;
            r_cnt        <= '0;
            r_out_cnt    <= '0;
            r_issue_done <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    r_cnt        <= '0;
                    r_out_cnt    <= '0;
                    r_issue_done <= 1'b0;
                    if (bus.cmd_valid) begin
                        case (bus.cmd)
                            2'b01:   r_state <= c_ST_LOAD;
                            2'b10:   r_state <= c_ST_COMPUTE;
                            2'b11:   r_state <= c_ST_UNLOAD;
                            default: r_state <= c_ST_IDLE;
                        endcase
                    end
                end
                c_ST_LOAD: begin
                    if (bus.in_valid) begin
                        if (r_cnt == c_LAST) begin
                            r_state <= c_ST_IDLE;
                            r_done  <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                c_ST_COMPUTE: begin
                    if (w_push && bus.bf_last) r_state <= c_ST_DRAIN;
                end
                c_ST_DRAIN: begin
                    // Only the final request remains, and it writes back this cycle
                    if (r_dl_vld[WB_LATENCY-2:0] == '0) begin
                        r_state <= c_ST_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                c_ST_UNLOAD: begin
                    if (w_issue) begin
                        if (r_cnt == c_LAST) r_issue_done <= 1'b1;
                        else                 r_cnt        <= r_cnt + 1'b1;
                    end
                    if (w_pop) begin
                        if (r_out_cnt == c_LAST) begin
                            r_state <= c_ST_IDLE;
                            r_done  <= 1'b1;
                        end else begin
                            r_out_cnt <= r_out_cnt + 1'b1;
                        end
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign bus.busy         = (r_state != c_ST_IDLE);
    assign bus.done         = r_done;
    assign bus.in_ready     = (r_state == c_ST_LOAD);
    assign bus.out_valid    = w_out_valid;
    assign bus.out_data     = r_fifo[r_rd_ptr];
    assign bus.bf_q0        = r_swap ? r_rdata_b1 : r_rdata_b0;
    assign bus.bf_q1        = r_swap ? r_rdata_b0 : r_rdata_b1;
    assign bus.bf_q_valid   = r_bf_q_valid;
    assign bus.conflict_err = r_conflict;
endmodule
`default_nettype wire

// File: tb/tb_ntt_bank_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ntt_bank_mem_ctrl
// Purpose  : Directed self-checking bench for ntt_bank_mem_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ntt_bank_mem_ctrl;
    localparam int DW  = 14;
    localparam int LN  = 10;
    localparam int WBL = 7;
    localparam int N   = 1024;

    logic clk = 1'b0;
    logic rst;
    int   tests_run    = 0;
    int   tests_failed = 0;

    always #5 clk = ~clk;

    ntt_bank_mem_ctrl_if #(.DATA_WIDTH(DW), .LOG_N(LN)) bus ();

    ntt_bank_mem_ctrl #(
        .DATA_WIDTH (DW),
        .LOG_N      (LN),
        .WB_LATENCY (WBL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.cmd_valid = 1'b0;
        bus.cmd       = 2'b00;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        bus.bf_req    = 1'b0;
        bus.bf_addr0  = '0;
        bus.bf_addr1  = '0;
        bus.bf_last   = 1'b0;
        bus.bf_d0     = '0;
        bus.bf_d1     = '0;
    endtask

    task automatic send_cmd(input logic [1:0] c);
        bus.cmd_valid = 1'b1;
        bus.cmd       = c;
        tick();
        bus.cmd_valid = 1'b0;
        bus.cmd       = 2'b00;
    endtask

    task automatic load_index();
        for (int i = 0; i < N; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = DW'(i);
            tick();
        end
        bus.in_valid = 1'b0;
    endtask

    // Memory image after the write-back test: word0=100, word512=200, rest = index
    function automatic logic [DW-1:0] exp_word(input int idx, input bit wb);
        if (wb && idx == 0)   return DW'(100);
        if (wb && idx == 512) return DW'(200);
        return DW'(idx);
    endfunction

    task automatic run_unload(input bit stall, input bit wb, output int bad, output int unstable,
                              output int nwords, output int gaps, output logic saw_done);
        logic [3:0]    pat;
        logic [DW-1:0] prev_data;
        bit            prev_stall;
        int            cyc;
        pat        = 4'b1001;
        bad        = 0;
        unstable   = 0;
        nwords     = 0;
        gaps       = 0;
        prev_stall = 0;
        prev_data  = '0;
        cyc        = 0;
        send_cmd(2'b11);
        while (nwords < N && cyc < 6000) begin
            bus.out_ready = stall ? pat[cyc % 4] : 1'b1;
            if (prev_stall && (bus.out_valid !== 1'b1 || bus.out_data !== prev_data)) unstable++;
            if (bus.out_valid === 1'b1) begin
                if (bus.out_ready) begin
                    if (bus.out_data !== exp_word(nwords, wb)) bad++;
                    nwords++;
                end
                prev_stall = !bus.out_ready;
                prev_data  = bus.out_data;
            end else begin
                prev_stall = 0;
                if (nwords > 0) gaps++;
            end
            tick();
            cyc++;
        end
        bus.out_ready = 1'b0;
        saw_done = bus.done;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: busy=%b done=%b in_ready=%b, want 0 0 0", bus.busy, bus.done, bus.in_ready);
        end
        tests_run++;
        if (bus.out_valid !== 1'b0 || bus.bf_q_valid !== 1'b0 || bus.conflict_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_flags: out_valid=%b bf_q_valid=%b conflict_err=%b, want 0 0 0",
                     bus.out_valid, bus.bf_q_valid, bus.conflict_err);
        end
        tests_run++;
        if (bus.out_data !== '0 || bus.bf_q0 !== '0 || bus.bf_q1 !== '0) begin
            tests_failed++;
            $display("FAIL reset_data: out_data=%0d bf_q0=%0d bf_q1=%0d, want 0 0 0", bus.out_data, bus.bf_q0, bus.bf_q1);
        end
        rst = 1'b1;
        tick();
        send_cmd(2'b00);
        tests_run++;
        if (bus.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL cmd00_ignored: busy=%b, want 0", bus.busy);
        end
    endtask

    task automatic test_load_unload();
        int bad, unstable, nwords, gaps;
        logic saw_done;
        send_cmd(2'b01);
        tests_run++;
        if (bus.busy !== 1'b1 || bus.in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL load_enter: busy=%b in_ready=%b, want 1 1", bus.busy, bus.in_ready);
        end
        load_index();
        tests_run++;
        if (bus.done !== 1'b1 || bus.in_ready !== 1'b0 || bus.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL load_done: done=%b in_ready=%b busy=%b, want 1 0 0", bus.done, bus.in_ready, bus.busy);
        end
        tick();
        tests_run++;
        if (bus.done !== 1'b0) begin
            tests_failed++;
            $display("FAIL load_done_pulse: done=%b one cycle later, want 0", bus.done);
        end
        run_unload(1'b0, 1'b0, bad, unstable, nwords, gaps, saw_done);
        tests_run++;
        if (nwords !== N || bad !== 0) begin
            tests_failed++;
            $display("FAIL unload_data: words=%0d bad=%0d, want %0d 0", nwords, bad, N);
        end
        tests_run++;
        if (gaps !== 0) begin
            tests_failed++;
            $display("FAIL unload_rate: %0d idle cycles mid-stream, want 0", gaps);
        end
        tests_run++;
        if (saw_done !== 1'b1 || bus.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL unload_done: done=%b busy=%b, want 1 0", saw_done, bus.busy);
        end
    endtask

    task automatic test_backpressure();
        int bad, unstable, nwords, gaps;
        logic saw_done;
        run_unload(1'b1, 1'b0, bad, unstable, nwords, gaps, saw_done);
        tests_run++;
        if (nwords !== N || bad !== 0) begin
            tests_failed++;
            $display("FAIL bp_data: words=%0d bad=%0d, want %0d 0", nwords, bad, N);
        end
        tests_run++;
        if (unstable !== 0) begin
            tests_failed++;
            $display("FAIL bp_stable: %0d stalled cycles changed output, want 0", unstable);
        end
        tests_run++;
        if (saw_done !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_done: done=%b, want 1", saw_done);
        end
    endtask

    task automatic test_bf_routing();
        bit saw;
        send_cmd(2'b10);
        bus.bf_req   = 1'b1;
        bus.bf_addr0 = LN'(5);
        bus.bf_addr1 = LN'(4);
        bus.bf_last  = 1'b1;
        bus.bf_d0    = DW'(5);
        bus.bf_d1    = DW'(4);
        tick();
        bus.bf_req  = 1'b0;
        bus.bf_last = 1'b0;
        tests_run++;
        if (bus.bf_q_valid !== 1'b1 || bus.bf_q0 !== DW'(5) || bus.bf_q1 !== DW'(4) || bus.conflict_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL bf_route: valid=%b q0=%0d q1=%0d conflict=%b, want 1 5 4 0",
                     bus.bf_q_valid, bus.bf_q0, bus.bf_q1, bus.conflict_err);
        end
        saw = 0;
        for (int i = 0; i < 20 && !saw; i++) begin
            tick();
            if (bus.done === 1'b1) saw = 1;
        end
        tests_run++;
        if (saw !== 1'b1) begin
            tests_failed++;
            $display("FAIL bf_route_done: done seen=%b within 20 cycles, want 1", saw);
        end
    endtask

    task automatic test_writeback();
        send_cmd(2'b10);
        bus.bf_req   = 1'b1;
        bus.bf_addr0 = LN'(0);
        bus.bf_addr1 = LN'(512);
        bus.bf_last  = 1'b1;
        bus.bf_d0    = DW'(1111);
        bus.bf_d1    = DW'(2222);
        tick();
        bus.bf_req  = 1'b0;
        bus.bf_last = 1'b0;
        repeat (5) tick();
        tests_run++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL wb_early_t6: done=%b busy=%b, want 0 1", bus.done, bus.busy);
        end
        tick();
        bus.bf_d0 = DW'(100);
        bus.bf_d1 = DW'(200);
        tests_run++;
        if (bus.done !== 1'b0) begin
            tests_failed++;
            $display("FAIL wb_early_t7: done=%b, want 0", bus.done);
        end
        tick();
        bus.bf_d0 = DW'(1111);
        bus.bf_d1 = DW'(2222);
        tests_run++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL wb_done_t8: done=%b busy=%b, want 1 0", bus.done, bus.busy);
        end
    endtask

    task automatic test_conflict();
        bit saw;
        bus.bf_d0 = DW'(3);
        bus.bf_d1 = DW'(777);
        send_cmd(2'b10);
        bus.bf_req   = 1'b1;
        bus.bf_addr0 = LN'(3);
        bus.bf_addr1 = LN'(5);
        bus.bf_last  = 1'b0;
        tick();
        bus.bf_addr0 = LN'(7);
        bus.bf_addr1 = LN'(6);
        bus.bf_last  = 1'b1;
        tests_run++;
        if (bus.conflict_err !== 1'b1 || bus.bf_q0 !== DW'(3)) begin
            tests_failed++;
            $display("FAIL conflict_set: conflict=%b q0=%0d, want 1 3", bus.conflict_err, bus.bf_q0);
        end
        tick();
        bus.bf_req  = 1'b0;
        bus.bf_last = 1'b0;
        tests_run++;
        if (bus.conflict_err !== 1'b1 || bus.bf_q0 !== DW'(7) || bus.bf_q1 !== DW'(6)) begin
            tests_failed++;
            $display("FAIL conflict_clean_req: conflict=%b q0=%0d q1=%0d, want 1 7 6",
                     bus.conflict_err, bus.bf_q0, bus.bf_q1);
        end
        repeat (6) tick();
        bus.bf_d0 = DW'(7);
        bus.bf_d1 = DW'(6);
        saw = 0;
        for (int i = 0; i < 20 && !saw; i++) begin
            tick();
            bus.bf_d0 = DW'(3000);
            bus.bf_d1 = DW'(3001);
            if (bus.done === 1'b1) saw = 1;
        end
        tests_run++;
        if (saw !== 1'b1 || bus.conflict_err !== 1'b1) begin
            tests_failed++;
            $display("FAIL conflict_sticky: done seen=%b conflict=%b, want 1 1", saw, bus.conflict_err);
        end
    endtask

    task automatic test_final_contents();
        int bad, unstable, nwords, gaps;
        logic saw_done;
        run_unload(1'b0, 1'b1, bad, unstable, nwords, gaps, saw_done);
        tests_run++;
        if (nwords !== N || bad !== 0) begin
            tests_failed++;
            $display("FAIL final_contents: words=%0d bad=%0d, want %0d 0", nwords, bad, N);
        end
    endtask

    task automatic test_async_reset();
        send_cmd(2'b01);
        for (int i = 0; i < 300; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = DW'(i);
            tick();
        end
        bus.in_data = DW'(300);
        #1;
        rst = 1'b0;
        #1;
        tests_run++;
        if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0 || bus.done !== 1'b0 || bus.conflict_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_reset: busy=%b in_ready=%b done=%b conflict=%b, want 0 0 0 0",
                     bus.busy, bus.in_ready, bus.done, bus.conflict_err);
        end
        #2;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        tick();
        tests_run++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_no_done: busy=%b done=%b, want 0 0", bus.busy, bus.done);
        end
        send_cmd(2'b01);
        tests_run++;
        if (bus.busy !== 1'b1 || bus.in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reload_enter: busy=%b in_ready=%b, want 1 1", bus.busy, bus.in_ready);
        end
        load_index();
        tests_run++;
        if (bus.done !== 1'b1) begin
            tests_failed++;
            $display("FAIL reload_done: done=%b, want 1", bus.done);
        end
    endtask

    initial begin
        test_reset();
        test_load_unload();
        test_backpressure();
        test_bf_routing();
        test_writeback();
        test_conflict();
        test_final_contents();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/ntt_bank_mem_ctrl.md
Name: ntt_bank_mem_ctrl

Overview:
Parametrised dual-bank coefficient memory and sequencer for the radix-2 NTT datapath. It is the successor of the fixed 512x2-bank, fixed-delay storage in the poly-mul top. It owns host load and unload streaming with valid/ready handshakes, conflict-free bank mapping, and read routing to butterfly ports. It also delays write-back addresses internally to match the butterfly pipeline depth. It sits between the host interface and the butterfly/twiddle datapath.

Parameters:
DATA_WIDTH, 14, coefficient width
LOG_N, 10, log2 of polynomial length N (N coefficients; each bank N/2 words)
WB_LATENCY, 7, cycles from bf_req to matching bf_d0/bf_d1 write-back; legal range 2..31

Ports:
clk  in  1  clock, all logic rising-edge
rst  in  1  asynchronous, active-low reset
cmd_valid  in  1  command strobe, sampled only in IDLE
cmd  in  2  01 = LOAD, 10 = COMPUTE, 11 = UNLOAD, 00 = ignored
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse on return to IDLE
in_valid / in_ready  in / out  1 / 1  load handshake
in_data  in  DATA_WIDTH  coefficient in natural order
out_valid / out_ready  out / in  1 / 1  unload handshake
out_data  out  DATA_WIDTH  coefficient in natural order
bf_req  in  1  butterfly read request (COMPUTE only)
bf_addr0, bf_addr1  in  LOG_N  logical coefficient addresses
bf_last  in  1  qualifies final bf_req of the operation
bf_q0, bf_q1  out  DATA_WIDTH  data at bf_addr0 / bf_addr1
bf_q_valid  out  1  qualifies bf_q*
bf_d0, bf_d1  in  DATA_WIDTH  write-back data, consumed WB_LATENCY cycles after the request
conflict_err  out  1  sticky bank-conflict flag

Behaviour:
- Reset (rst=0, async): state IDLE. busy, done, in_ready, out_valid, bf_q_valid and conflict_err are all 0. out_data, bf_q0 and bf_q1 are 0. The delay line is cleared. Memory contents are undefined.
- Map: bank(a) = XOR-reduce of a; row(a) = a[LOG_N-1:1]. Any two addresses differing in one bit land in opposite banks.
- IDLE: on cmd_valid, go to LOAD, COMPUTE or UNLOAD, with busy high next cycle. cmd 00 is ignored. cmd_valid outside IDLE is ignored.
- LOAD:
  - in_ready is high.
  - Each in_valid&in_ready beat writes word at counter c (0..N-1) and increments c.
  - After beat N-1: in_ready drops, go to IDLE, done pulses.
  - Gaps in in_valid are allowed.
- COMPUTE:
  - bf_req at cycle t reads both banks. bf_q0/bf_q1 are swapped as needed so port0 corresponds to bf_addr0. bf_q_valid is high at t+1.
  - bf_req, row0, row1 and bank0 enter a WB_LATENCY-deep delay line. At t+WB_LATENCY, bf_d0 is written to addr0's location and bf_d1 to addr1's.
  - Same-row read and write in one cycle is read-first: old data is returned.
  - If bf_req has bank(bf_addr0)==bank(bf_addr1): conflict_err sets and stays set until reset. The access is still performed with addr0 winning both read and write.
  - bf_req with bf_last moves to DRAIN.
  - bf_req outside COMPUTE is ignored; no read and no delay-line entry.
- DRAIN: no new requests are accepted. Outstanding write-backs complete. After the delay line empties, go to IDLE and done pulses. Total is WB_LATENCY cycles after the bf_last request.
- UNLOAD:
  - Reads are issued in natural order into a 2-entry output FIFO. Issue only when the FIFO has space counting in-flight reads.
  - Sustained rate is 1 word/cycle while out_ready=1.
  - out_data and out_valid are stable while out_valid & !out_ready.
  - After beat N-1 is accepted: go to IDLE, done pulses.
- Counter wrap: no wrap. The counter stops at N-1, and the terminal beat ends the operation.
- Reset mid-operation: aborts immediately to IDLE. No done pulse is produced. Pending write-backs are discarded.

Test Plan:
- Load then unload: LOAD with in_data = index (0..1023) and continuous valid; UNLOAD with out_ready=1 -> out_data = 0..1023 in order, one per cycle. done pulses once per operation.
- Backpressure: UNLOAD with out_ready toggled 1,0,0,1 -> no word dropped or duplicated, out_data stable while stalled, all 1024 words correct.
- Butterfly read routing: after load of index values, bf_req with addr0=5, addr1=4 -> next cycle bf_q0=5, bf_q1=4, bf_q_valid=1, conflict_err=0.
- Write-back latency: bf_req addr0=0, addr1=512 at t, bf_last=1; bf_d0=100, bf_d1=200 at t+7 -> done at t+7 (+1 registered). Unload shows word0=100, word512=200.
- Conflict: bf_req addr0=3, addr1=5 -> conflict_err=1 and stays 1 through later clean requests until rst=0.
- Async reset: assert rst=0 mid-LOAD at beat 300 -> busy, in_ready and done go 0 without a clock edge. A new LOAD is accepted after release.
